// File: rtl/serial_byte_assembler.sv
// serial_byte_assembler: serial-to-parallel word assembler with one-word output slot; optional ALL_ONES_EN adds all_ones
module serial_byte_assembler #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sin,
   input  logic             sin_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   input  logic             ovr_clr,
`ifdef ALL_ONES_EN
   output logic             all_ones,
`endif
   output logic             overrun
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic {EMPTY, FULL} slot_t;
   slot_t            state, state_n;
   logic [WIDTH-1:0] sreg, word;
   logic [CW-1:0]    cnt;
   logic             done, load, drop;
   // next shift value, completion and slot transitions
   always_comb begin
      word    = MSB_FIRST ? {sreg[WIDTH-2:0], sin} : {sin, sreg[WIDTH-1:1]};
      done    = sin_valid && cnt == CW'(WIDTH-1);
      load    = done && (state == EMPTY || out_ready);
      drop    = done && state == FULL && !out_ready;
      state_n = load ? FULL : (state == FULL && out_ready) ? EMPTY : state;
   end
   // shift register, bit counter, output slot and sticky overrun
   always_ff @(posedge clk) begin
      if (reset) begin
         sreg     <= '0;
         cnt      <= '0;
         state    <= EMPTY;
         out_data <= '0;
         overrun  <= 1'b0;
      end else begin
         if (sin_valid) sreg <= word;
         if (sin_valid) cnt <= done ? '0 : cnt + CW'(1);
         state    <= state_n;
         if (load) out_data <= word;
         overrun  <= drop ? 1'b1 : ovr_clr ? 1'b0 : overrun;
      end
   end
`ifdef ALL_ONES_EN
   // registered AND of each word, loaded alongside out_data
   always_ff @(posedge clk) begin
      if (reset) all_ones <= 1'b0;
      else if (load) all_ones <= &word;
   end
`endif
   assign out_valid = state == FULL;
endmodule
